dp_mem_arbiter: RTL and testbench

- Round-robin arbiter that shares the 16x8 dual-port memory between NUM_REQ requesters.
- Write port and read port are arbitrated independently, so at most one write and one read are issued per cycle.
- Sits between client blocks and the memory. It drives the memory's enb/wr/rd/w_addr/r_addr/w_data and returns read data tagged with the requester ID.

---
 rtl/dp_mem_arbiter_if.sv | 37 +++
 rtl/dp_mem_arbiter.sv | 105 ++++++++++
 tb/tb_dp_mem_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dp_mem_arbiter_if.sv
// dp_mem_arbiter_if: requester-side and memory-side bus of dp_mem_arbiter
interface dp_mem_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ*ADDR_W-1:0] req_waddr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_rd;
    logic [NUM_REQ*ADDR_W-1:0] req_raddr;
    logic [NUM_REQ-1:0]        gnt_wr;
    logic [NUM_REQ-1:0]        gnt_rd;
    logic                      err_wr;
    logic                      err_rd;
    logic                      rvalid;
    logic [ID_W-1:0]           rid;
    logic [DATA_W-1:0]         rdata;
    logic                      mem_enb;
    logic                      mem_wr;
    logic                      mem_rd;
    logic [ADDR_W-1:0]         mem_w_addr;
    logic [ADDR_W-1:0]         mem_r_addr;
    logic [DATA_W-1:0]         mem_w_data;
    logic [DATA_W-1:0]         mem_r_data;
    modport master (
        output req_wr, req_waddr, req_wdata, req_rd, req_raddr, mem_r_data,
        input  gnt_wr, gnt_rd, err_wr, err_rd, rvalid, rid, rdata,
               mem_enb, mem_wr, mem_rd, mem_w_addr, mem_r_addr, mem_w_data
    );
    modport slave (
        input  req_wr, req_waddr, req_wdata, req_rd, req_raddr, mem_r_data,
        output gnt_wr, gnt_rd, err_wr, err_rd, rvalid, rid, rdata,
               mem_enb, mem_wr, mem_rd, mem_w_addr, mem_r_addr, mem_w_data
    );
endinterface

// File: rtl/dp_mem_arbiter.sv
// dp_mem_arbiter: round-robin write/read port arbiter for a dual-port memory; ARB_WR_BYPASS_EN forwards same-address write data to the read
module dp_mem_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16
) (
    input logic           clk,
    input logic           rst,
    dp_mem_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]   wr_ptr, rd_ptr, w_win, r_win;
    logic              w_hit, r_hit, w_ok, r_ok, w_go, r_go;
    logic [ADDR_W-1:0] w_addr, r_addr;
    logic [DATA_W-1:0] w_data;

    // First asserted request at or after ptr, wrapping modulo NUM_REQ; MSB flags a hit.
    function automatic logic [ID_W:0] pick(input logic [NUM_REQ-1:0] req, input logic [ID_W-1:0] ptr);
        logic [ID_W:0] res, s;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            s = {1'b0, ptr} + (ID_W + 1)'(k);
            if (s >= (ID_W + 1)'(NUM_REQ)) s = s - (ID_W + 1)'(NUM_REQ);
            if (req[s[ID_W-1:0]]) res = {1'b1, s[ID_W-1:0]};
        end
        return res;
    endfunction

    function automatic logic [ID_W-1:0] nxt(input logic [ID_W-1:0] p);
        return (p == ID_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pick winners per port and mux their address/data slices.
    always_comb begin
        {w_hit, w_win} = pick(bus.req_wr, wr_ptr);
        {r_hit, r_win} = pick(bus.req_rd, rd_ptr);
        w_addr = '0;
        w_data = '0;
        r_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == ID_W'(i)) w_addr = bus.req_waddr[i*ADDR_W +: ADDR_W];
            if (w_win == ID_W'(i)) w_data = bus.req_wdata[i*DATA_W +: DATA_W];
            if (r_win == ID_W'(i)) r_addr = bus.req_raddr[i*ADDR_W +: ADDR_W];
        end
        w_ok = {1'b0, w_addr} < (ADDR_W + 1)'(DEPTH);
        r_ok = {1'b0, r_addr} < (ADDR_W + 1)'(DEPTH);
        w_go = rst & w_hit & w_ok;
        r_go = rst & r_hit & r_ok;
    end

    // Grants, error flags and memory drive; everything is held low while in reset.
    always_comb begin
        bus.gnt_wr = '0;
        bus.gnt_rd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.gnt_wr[i] = rst & w_hit & (w_win == ID_W'(i));
            bus.gnt_rd[i] = rst & r_hit & (r_win == ID_W'(i));
        end
        bus.err_wr     = rst & w_hit & ~w_ok;
        bus.err_rd     = rst & r_hit & ~r_ok;
        bus.mem_wr     = w_go;
        bus.mem_rd     = r_go;
        bus.mem_enb    = w_go | r_go;
        bus.mem_w_addr = w_go ? w_addr : '0;
        bus.mem_w_data = w_go ? w_data : '0;
        bus.mem_r_addr = r_go ? r_addr : '0;
    end

    // Pointers advance past any granted winner (out-of-range included); read tag follows the memory's one-cycle latency.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            bus.rvalid <= 1'b0;
            bus.rid    <= '0;
        end else begin
            if (w_hit) wr_ptr <= nxt(w_win);
            if (r_hit) rd_ptr <= nxt(r_win);
            bus.rvalid <= r_go;
            if (r_go) bus.rid <= r_win;
        end
    end

`ifdef ARB_WR_BYPASS_EN
    logic              byp_sel;
    logic [DATA_W-1:0] byp_data;

    // Capture write data when it collides with a read of the same word so the read sees the new value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            byp_sel  <= 1'b0;
            byp_data <= '0;
        end else begin
            byp_sel  <= w_go & r_go & (w_addr == r_addr);
            byp_data <= w_data;
        end
    end

    assign bus.rdata = byp_sel ? byp_data : bus.mem_r_data;
`else
    assign bus.rdata = bus.mem_r_data;
`endif
endmodule

// File: tb/tb_dp_mem_arbiter.sv
// tb_dp_mem_arbiter: directed scoreboard bench for dp_mem_arbiter with a 16x8 read-before-write memory model
module tb_dp_mem_arbiter;
    localparam int N = 2, AW = 5, DW = 8, DEPTH = 16;

    typedef struct {
        int         due;
        logic [0:0] rid;
        logic [7:0] data;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0, n_pass = 0, n_total = 0;
    logic [7:0] mem [16];
    logic [7:0] ref_mem [16];
    rd_exp_t exp_q[$];
    rd_exp_t e;
    logic ev;

    dp_mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
    dp_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: registered read, read-before-write.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h40 + 8'(i);
        end else if (bus.mem_enb) begin
            if (bus.mem_rd) bus.mem_r_data <= mem[bus.mem_r_addr[3:0]];
            if (bus.mem_wr) mem[bus.mem_w_addr[3:0]] <= bus.mem_w_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    // Read scoreboard: rvalid must match exactly the cycles an expected read is due.
    always @(negedge clk) begin
        ev = (exp_q.size() != 0) && (exp_q[0].due == cyc);
        chk("rvalid", 32'(bus.rvalid), 32'(ev));
        if (ev) begin
            e = exp_q.pop_front();
            chk("rid", 32'(bus.rid), 32'(e.rid));
            chk("rdata", 32'(bus.rdata), 32'(e.data));
        end
    end

    task automatic step(input logic r, input logic [1:0] wr, input logic [4:0] wa0, wa1,
                        input logic [7:0] wd0, wd1, input logic [1:0] rd, input logic [4:0] ra0, ra1,
                        input logic [1:0] egw, egr, input logic eew, eer);
        logic ew_ok, er_ok;
        logic [4:0] xwa, xra;
        logic [7:0] xwd, xrd;
        @(negedge clk);
        rst           = r;
        bus.req_wr    = wr;
        bus.req_waddr = {wa1, wa0};
        bus.req_wdata = {wd1, wd0};
        bus.req_rd    = rd;
        bus.req_raddr = {ra1, ra0};
        #1;
        ew_ok = (egw != 2'b00) && !eew;
        er_ok = (egr != 2'b00) && !eer;
        xwa = ew_ok ? (egw[1] ? wa1 : wa0) : 5'd0;
        xwd = ew_ok ? (egw[1] ? wd1 : wd0) : 8'd0;
        xra = er_ok ? (egr[1] ? ra1 : ra0) : 5'd0;
        chk("gnt_wr", 32'(bus.gnt_wr), 32'(egw));
        chk("gnt_rd", 32'(bus.gnt_rd), 32'(egr));
        chk("err_wr", 32'(bus.err_wr), 32'(eew));
        chk("err_rd", 32'(bus.err_rd), 32'(eer));
        chk("mem_wr", 32'(bus.mem_wr), 32'(ew_ok));
        chk("mem_rd", 32'(bus.mem_rd), 32'(er_ok));
        chk("mem_enb", 32'(bus.mem_enb), 32'(ew_ok | er_ok));
        chk("mem_w_addr", 32'(bus.mem_w_addr), 32'(xwa));
        chk("mem_w_data", 32'(bus.mem_w_data), 32'(xwd));
        chk("mem_r_addr", 32'(bus.mem_r_addr), 32'(xra));
        if (er_ok) begin
            xrd = ref_mem[xra[3:0]];
`ifdef ARB_WR_BYPASS_EN
            if (ew_ok && xwa == xra) xrd = xwd;
`endif
            exp_q.push_back('{due: cyc + 1, rid: egr[1], data: xrd});
        end
        if (ew_ok) ref_mem[xwa[3:0]] = xwd;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h40 + 8'(i);
        rst = 1'b0;
        bus.req_wr = 2'b11; bus.req_waddr = '0; bus.req_wdata = '0;
        bus.req_rd = 2'b11; bus.req_raddr = '0;
        // reset held with all requests high
        repeat (3) step(0, 2'b11, 5'd1, 5'd2, 8'h5A, 8'h5B, 2'b11, 5'd1, 5'd2, 2'b00, 2'b00, 0, 0);
        // round robin on both ports, back-to-back reads
        step(1, 2'b11, 5'd8, 5'd9, 8'h80, 8'h90, 2'b11, 5'd2, 5'd6, 2'b01, 2'b01, 0, 0);
        step(1, 2'b11, 5'd8, 5'd9, 8'h81, 8'h91, 2'b11, 5'd2, 5'd6, 2'b10, 2'b10, 0, 0);
        step(1, 2'b11, 5'd8, 5'd9, 8'h82, 8'h92, 2'b00, 5'd0, 5'd0, 2'b01, 2'b00, 0, 0);
        step(1, 2'b11, 5'd8, 5'd9, 8'h83, 8'h93, 2'b00, 5'd0, 5'd0, 2'b10, 2'b00, 0, 0);
        // read path: write A5 at 5, read it back on requester 1
        step(1, 2'b01, 5'd5, 5'd0, 8'hA5, 8'h00, 2'b00, 5'd0, 5'd0, 2'b01, 2'b00, 0, 0);
        step(1, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b10, 5'd0, 5'd5, 2'b00, 2'b10, 0, 0);
        step(1, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 0, 0);
        // out of range write, then read of the aliasing address, then out of range read
        step(1, 2'b01, 5'd20, 5'd0, 8'hEE, 8'h00, 2'b00, 5'd0, 5'd0, 2'b01, 2'b00, 1, 0);
        step(1, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b01, 5'd4, 5'd0, 2'b00, 2'b01, 0, 0);
        step(1, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b10, 5'd0, 5'd25, 2'b00, 2'b10, 0, 1);
        // collision at address 3
        step(1, 2'b10, 5'd0, 5'd3, 8'h00, 8'h11, 2'b00, 5'd0, 5'd0, 2'b10, 2'b00, 0, 0);
        step(1, 2'b01, 5'd3, 5'd0, 8'h22, 8'h00, 2'b10, 5'd0, 5'd3, 2'b01, 2'b10, 0, 0);
        step(1, 2'b10, 5'd0, 5'd11, 8'h00, 8'h77, 2'b01, 5'd3, 5'd0, 2'b10, 2'b01, 0, 0);
        // simultaneous ports, then contention shows both pointers moved
        step(1, 2'b01, 5'd10, 5'd0, 8'h5C, 8'h00, 2'b10, 5'd0, 5'd8, 2'b01, 2'b10, 0, 0);
        step(1, 2'b11, 5'd12, 5'd13, 8'h60, 8'h61, 2'b11, 5'd10, 5'd9, 2'b10, 2'b01, 0, 0);
        // reset mid-operation, then grants restart at requester 0
        step(0, 2'b11, 5'd12, 5'd13, 8'h60, 8'h61, 2'b11, 5'd10, 5'd9, 2'b00, 2'b00, 0, 0);
        step(1, 2'b11, 5'd12, 5'd13, 8'h60, 8'h61, 2'b11, 5'd10, 5'd9, 2'b01, 2'b01, 0, 0);
        repeat (3) step(1, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 0, 0);
        @(negedge clk);
        #1;
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
